// File: rtl/array_reader.sv
// array_reader: streams a burst of array words over valid/ready through a 2-entry prefetch buffer
module array_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] rem, len_c;
  logic in_flight, fl_last, wp, rp, pop, kill;
  logic [1:0] cnt;
  logic [DATA_W-1:0] buf_d [2];
  logic [1:0] buf_l;
  assign len_c = len > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : len;
  assign busy = state != IDLE;
  assign kill = busy && abort;
  assign out_valid = cnt != 2'd0;
  assign out_data = buf_d[rp];
  assign out_last = out_valid && buf_l[rp];
  assign pop = out_valid && out_ready;
  assign rd_addr = addr;
  // a read may issue only if the word it returns is guaranteed a buffer slot
  assign rd_en = state == RUN && !abort && rem != '0 &&
                 ({1'b0, cnt} + {2'b0, in_flight} < 3'd2 + {2'b0, pop});
  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_n;
  end
  // next state: abort outranks progress, start only counts when idle
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? ((start && len != '0) ? RUN : IDLE) :
              abort ? IDLE :
              (state == RUN && rd_en && rem == (ADDR_W+1)'(1)) ? DRAIN :
              (state == DRAIN && pop && out_last) ? IDLE : state;
  end
  // read issue bookkeeping, prefetch buffer and completion pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr <= '0;
      rem <= '0;
      in_flight <= 1'b0;
      fl_last <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      buf_d[0] <= '0;
      buf_d[1] <= '0;
      buf_l <= 2'b00;
      done <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr <= start_addr;
        rem <= len_c;
      end else if (rd_en) begin
        addr <= addr + 1'b1;
        rem <= rem - 1'b1;
      end
      in_flight <= rd_en;
      fl_last <= rem == (ADDR_W+1)'(1);
      if (kill) begin
        wp <= 1'b0;
        rp <= 1'b0;
        cnt <= 2'd0;
      end else begin
        if (in_flight) begin
          buf_d[wp] <= rd_data;
          buf_l[wp] <= fl_last;
          wp <= ~wp;
        end
        if (pop) rp <= ~rp;
        cnt <= cnt + {1'b0, in_flight} - {1'b0, pop};
      end
      done <= (state == IDLE && start && len == '0) || (busy && !abort && pop && out_last);
    end
  end
endmodule

// File: tb/tb_array_reader.sv
// tb_array_reader: table, hand-written and random bursts checked against a queue-based stream model
module tb_array_reader;
  localparam int DW = 32, DEPTH = 128, AW = 7;
  logic clock = 0, resetn = 0, start = 0, abort = 0, out_ready = 0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0] len = '0;
  logic rd_en, out_valid, out_last, busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0, out_data;

  array_reader #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .start(start), .start_addr(start_addr), .len(len),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));

  always #5 clock = ~clock;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) rd_data <= rd_en ? mem[rd_addr] : $urandom;

  int checks = 0, failures = 0, cyc = 0, t0 = 0, ready_mode = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial forever begin
    @(posedge clock);
    #1;
    out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  logic [DW-1:0] got_d [$];
  bit got_l [$];
  int got_c [$], rd_a [$], rd_c [$], done_c [$];
  bit busy_seen = 0, pstall = 0, pl = 0, pabort = 0;
  logic [DW-1:0] pd = '0;
  int outst = 0;

  always @(negedge clock) begin
    if (!resetn) begin
      outst = 0;
      pstall = 0;
    end else begin
      if (pstall && !pabort)
        chk(out_valid && out_data == pd && out_last == pl, "stall_hold", out_data, pd);
      if (rd_en) begin
        rd_a.push_back(int'(rd_addr));
        rd_c.push_back(cyc);
        chk(outst + 1 - int'(out_valid && out_ready) <= 2, "occupancy",
            outst + 1 - int'(out_valid && out_ready), 2);
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        got_c.push_back(cyc);
      end
      if (done) done_c.push_back(cyc);
      if (busy) busy_seen = 1;
      outst = (abort && busy) ? 0 : outst + int'(rd_en) - int'(out_valid && out_ready);
      pstall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      pabort = abort;
    end
  end

  task automatic clr();
    got_d.delete(); got_l.delete(); got_c.delete();
    rd_a.delete(); rd_c.delete(); done_c.delete();
    busy_seen = 0;
  endtask

  task automatic do_start(input int a, input int l);
    @(posedge clock);
    #1;
    clr();
    start = 1; start_addr = AW'(a); len = (AW+1)'(l); t0 = cyc;
    @(posedge clock);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (done_c.size() > 0) begin ok = 1; break; end
      @(negedge clock);
      #1;
    end
    if (!ok) chk(0, "done_timeout", cyc, lim);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_burst(input int a, input int l);
    int n = l > DEPTH ? DEPTH : l;
    int bad = -1, badr = -1;
    chk(got_d.size() == n, "word_count", got_d.size(), n);
    chk(rd_a.size() == n, "read_count", rd_a.size(), n);
    for (int k = 0; k < n; k++) begin
      if (bad < 0 && k < got_d.size() && (got_d[k] != mem[(a + k) % DEPTH] || got_l[k] != (k == n - 1))) bad = k;
      if (badr < 0 && k < rd_a.size() && rd_a[k] != (a + k) % DEPTH) badr = k;
    end
    chk(bad < 0, "stream_word_index", bad, -1);
    chk(badr < 0, "read_addr_index", badr, -1);
    chk(done_c.size() == 1, "done_pulses", done_c.size(), 1);
    if (done_c.size() == 1 && (n == 0 || got_c.size() > 0))
      chk(done_c[0] == (n == 0 ? t0 + 1 : got_c[got_c.size() - 1] + 1), "done_cycle", done_c[0],
          n == 0 ? t0 + 1 : got_c[got_c.size() - 1] + 1);
    if (n == 0) chk(!busy_seen, "len0_busy", busy_seen, 0);
    chk(!busy, "idle_after", busy, 0);
  endtask

  task automatic run_burst(input int a, input int l, input int mode);
    ready_mode = mode;
    do_start(a, l);
    wait_done(3000);
    check_burst(a, l);
  endtask

  typedef struct { int a; int l; int mode; int n; int first; int lastw; } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{5, 4, 0, 4, 105, 108};
    tbl[1] = '{126, 4, 0, 4, 226, 101};
    tbl[2] = '{10, 6, 2, 6, 110, 115};
    tbl[3] = '{0, 200, 0, 128, 100, 227};
    tbl[4] = '{127, 1, 1, 1, 227, 227};
    tbl[5] = '{64, 128, 1, 128, 164, 163};
    tbl[6] = '{3, 0, 0, 0, 0, 0};
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
    #2;
    chk({rd_en, rd_addr, out_valid, out_data, out_last, busy, done} == '0, "reset_outputs",
        {rd_en, rd_addr, out_valid, out_data, out_last, busy, done}, 0);
    repeat (2) @(posedge clock);
    #3;
    resetn = 1;

    ready_mode = 0;
    do_start(5, 4);
    chk(busy, "busy_after_start", busy, 1);
    wait_done(50);
    for (int k = 0; k < 4; k++) begin
      chk(k < rd_c.size() && rd_c[k] == t0 + 1 + k && rd_a[k] == 5 + k, "exact_read",
          k < rd_c.size() ? rd_c[k] - t0 : -1, 1 + k);
      chk(k < got_c.size() && got_c[k] == t0 + 3 + k && got_d[k] == 32'(105 + k) && got_l[k] == (k == 3),
          "exact_word", k < got_c.size() ? got_c[k] - t0 : -1, 3 + k);
    end
    chk(done_c.size() == 1 && done_c[0] == t0 + 7, "exact_done",
        done_c.size() > 0 ? done_c[0] - t0 : -1, 7);

    foreach (tbl[i]) begin
      run_burst(tbl[i].a, tbl[i].l, tbl[i].mode);
      chk(got_d.size() == tbl[i].n, "tbl_count", got_d.size(), tbl[i].n);
      if (tbl[i].n > 0 && got_d.size() == tbl[i].n) begin
        chk(got_d[0] == 32'(tbl[i].first), "tbl_first", got_d[0], tbl[i].first);
        chk(got_d[tbl[i].n - 1] == 32'(tbl[i].lastw), "tbl_last", got_d[tbl[i].n - 1], tbl[i].lastw);
      end
    end

    ready_mode = 0;
    do_start(20, 10);
    for (int i = 0; i < 50 && got_d.size() < 3; i++) begin
      @(negedge clock);
      #1;
    end
    chk(got_d.size() >= 3, "abort_wait", got_d.size(), 3);
    @(posedge clock);
    #1;
    abort = 1;
    @(posedge clock);
    #1;
    abort = 0;
    chk(!out_valid && !busy, "abort_idle", {out_valid, busy}, 0);
    repeat (6) @(posedge clock);
    #1;
    chk(done_c.size() == 0, "abort_no_done", done_c.size(), 0);
    chk(got_d.size() == 4, "abort_words", got_d.size(), 4);
    for (int k = 0; k < got_d.size() && k < 4; k++)
      chk(got_d[k] == 32'(120 + k), "abort_data", got_d[k], 120 + k);
    run_burst(50, 2, 0);

    ready_mode = 0;
    do_start(0, 8);
    repeat (3) @(posedge clock);
    #3;
    chk(out_valid && busy, "pre_reset_active", {out_valid, busy}, 3);
    resetn = 0;
    #1;
    chk({rd_en, rd_addr, out_valid, out_data, out_last, busy, done} == '0, "async_reset_outputs",
        {rd_en, rd_addr, out_valid, out_data, out_last, busy, done}, 0);
    @(posedge clock);
    #3;
    resetn = 1;
    clr();
    repeat (6) @(posedge clock);
    #1;
    chk(!busy_seen && rd_c.size() == 0 && got_d.size() == 0 && done_c.size() == 0, "post_reset_idle",
        rd_c.size() + got_d.size(), 0);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 20),
                $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/array_reader.md
Name: array_reader

Overview:
- Streaming reader for the 128-entry x 32-bit register arrays used across the game datapath.
- On a start command it issues sequential reads into a 1-cycle-latency array read port.
- Read data is returned on a valid/ready stream, in address order, with a last flag.
- A 2-entry prefetch buffer sustains one word per cycle when the consumer is always ready.

Parameters:
- DATA_W, 32, width of each array entry and of the output stream.
- DEPTH, 128, number of array entries.
- ADDR_W, 7, address width; must satisfy 2^ADDR_W == DEPTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  begin a burst; honoured only in IDLE.
- start_addr  input  ADDR_W  first entry to read; sampled with start.
- len  input  ADDR_W+1  number of words to read; sampled with start.
- abort  input  1  synchronous cancel of the burst in progress.
- rd_en  output  1  read strobe to the array.
- rd_addr  output  ADDR_W  read address; meaningful only while rd_en=1.
- rd_data  input  DATA_W  array read data, valid exactly one cycle after rd_en.
- out_valid  output  1  stream word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  stream word.
- out_last  output  1  current word is the final word of the burst.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse marking burst completion.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, state=IDLE. Reset also clears the buffer, the in-flight flag and all counters.
- Reset is asynchronous and takes effect mid-burst. Any read in flight is discarded.
- States:
  - IDLE: idle.
  - RUN: reads still to issue.
  - DRAIN: all reads issued; words still in flight or buffered.
- IDLE:
  - On start with len != 0: latch start_addr and len (clamp len > DEPTH to DEPTH), go to RUN, busy=1 next cycle.
  - On start with len == 0: no reads issued, busy stays 0, done pulses in the next cycle.
- start while busy=1 is ignored.
- Read issue (RUN): rd_en=1 in a cycle only when remaining_reads > 0 and (buffered + in_flight − pop_this_cycle) < 2. This guarantees the buffer never overflows.
  - rd_addr starts at start_addr and increments by 1 per issued read, wrapping modulo DEPTH (127 -> 0).
- First read: rd_en is high in the cycle after the start cycle, provided abort=0 in that cycle.
- Data path:
  - rd_data is written into the buffer at the end of the cycle after rd_en.
  - out_valid rises in the following cycle, so the first word appears 3 cycles after the start cycle.
- Stream rules:
  - Handshake occurs when out_valid && out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on abort or reset.
- Throughput: with out_ready held at 1, words are delivered on consecutive cycles.
- out_last=1 only on the word whose index == len−1 within the burst.
- RUN -> DRAIN when the last read issues. DRAIN -> IDLE on the handshake of the out_last word.
- done pulses for one cycle in the cycle after the last handshake. busy falls in that same cycle.
- abort (RUN or DRAIN):
  - Next cycle: state=IDLE, out_valid=0, busy=0, no done pulse.
  - Buffer is flushed; a read in flight is dropped; rd_en is 0 in the abort cycle itself.
  - abort in IDLE is ignored. If abort and start coincide in IDLE, start wins.
- A handshake in the same cycle as abort still counts for the consumer. No further words follow.
- A new start is accepted in the cycle where done=1 (state is already IDLE).

Test Plan:
- Burst of 4 words, array[i]=i+100, out_ready held at 1:
  - Start at start_addr=5, len=4.
  - Required: rd_en in cycles 1-4 with rd_addr 5,6,7,8; out_data 105,106,107,108 in cycles 3-6; out_last only on 108; done in cycle 7.
- Wrap-around: start_addr=126, len=4 -> rd_addr 126,127,0,1; stream 226,227,100,101.
- Backpressure: len=6, out_ready toggled 1,0,0,1,…
  - Required: no word lost or duplicated; out_data stable while stalled.
  - Required: rd_en never issued when buffer+in-flight would exceed 2.
- len=0 -> no rd_en, busy stays 0, done one cycle later. len=200 -> exactly 128 words delivered.
- Abort mid-burst: len=10, abort after 3 handshakes -> out_valid=0 next cycle, no done. A following start with len=2 delivers exactly 2 fresh words.
- Async reset mid-burst: resetn low between clock edges -> all outputs immediately at reset values. After release, idle until start.
